// File: rtl/mdr_mem_ctrl.sv
// Memory data register sequencer: owns the MDR and runs load/store accesses
// against the 8-bit data memory with a ready handshake and a cycle timeout.
module mdr_mem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_req,
  input  logic        st_req,
  input  logic        mdr_wr,
  input  logic [15:0] c_bus,
  input  logic [15:0] mar,
  input  logic [7:0]  dmem_rdata,
  input  logic        dmem_ready,
  output logic [15:0] dmem_addr,
  output logic [7:0]  dmem_wdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] mdr_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state_dbg
);

  // Handshake: a strobe (dmem_read or dmem_write) is the request, dmem_ready is
  // the response; a transfer completes on the first rising edge where the strobe
  // is high and dmem_ready=1, and address/write data hold until then.

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0]      mdr_nxt, addr_nxt;
  logic [7:0]       wdata_nxt;
  logic             rd_nxt, wr_nxt, done_nxt, err_nxt;
  logic             cnt_expired;

  assign state_dbg   = state;
  assign cnt_expired = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdr_nxt   = mdr_out;
    addr_nxt  = dmem_addr;
    wdata_nxt = dmem_wdata;
    rd_nxt    = dmem_read;
    wr_nxt    = dmem_write;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        // Fixed priority; losing commands in the same cycle are dropped.
        if (ld_req) begin
          addr_nxt  = mar;
          rd_nxt    = 1'b1;
          wr_nxt    = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_RD_WAIT;
        end else if (st_req) begin
          addr_nxt  = mar;
          wdata_nxt = mdr_out[7:0];
          wr_nxt    = 1'b1;
          rd_nxt    = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_WR_WAIT;
        end else if (mdr_wr) begin
          mdr_nxt = c_bus;
        end
      end
      S_RD_WAIT: begin
        if (dmem_ready) begin
          mdr_nxt   = {8'h00, dmem_rdata};
          rd_nxt    = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else if (cnt_expired) begin
          rd_nxt    = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WR_WAIT: begin
        if (dmem_ready) begin
          wr_nxt    = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else if (cnt_expired) begin
          wr_nxt    = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: begin
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      mdr_out    <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      mdr_out    <= mdr_nxt;
      dmem_addr  <= addr_nxt;
      dmem_wdata <= wdata_nxt;
      dmem_read  <= rd_nxt;
      dmem_write <= wr_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      busy       <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Bench for mdr_mem_ctrl: directed scenarios plus random load/store/mdr_wr
// traffic, each access judged by transaction-level expectations.
module tb_mdr_mem_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req = 1'b0, st_req = 1'b0, mdr_wr = 1'b0;
  logic [15:0] c_bus = '0, mar = '0;
  logic [7:0]  dmem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic [15:0] dmem_addr, mdr_out;
  logic [7:0]  dmem_wdata;
  logic        dmem_read, dmem_write, busy, done, err;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mdr_model = '0;

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  mdr_mem_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .st_req(st_req), .mdr_wr(mdr_wr),
    .c_bus(c_bus), .mar(mar), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .mdr_out(mdr_out), .busy(busy), .done(done), .err(err),
    .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    ld_req = 1'b0; st_req = 1'b0; mdr_wr = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_mdr_wr(input logic [15:0] val);
    @(negedge clk);
    idle_inputs();
    mdr_wr = 1'b1;
    c_bus  = val;
    mdr_model = val;
    exp_q.push_back(val);
    @(negedge clk);
    mdr_wr = 1'b0;
    c_bus  = 16'($urandom);
    check("mdr_wr_value", 32'(mdr_out), 32'(exp_q.pop_front()));
    check("mdr_wr_busy", 32'(busy), 32'(0));
    check("mdr_wr_done", 32'(done), 32'(0));
  endtask

  // One access: lat = ready-low cycles before ready is offered.
  task automatic do_access(input bit ld, input bit st, input bit mw,
                           input logic [15:0] addr, input int lat, input logic [7:0] rd_val);
    int rd_cyc = 0, wr_cyc = 0, busy_cyc = 0, done_cnt = 0, err_cnt = 0;
    int addr_bad = 0, wdata_bad = 0, overlap = 0;
    int strobe_exp;
    bit ok;
    bit is_ld;
    logic [7:0]  wdata_exp;
    logic [15:0] mdr_exp;
    is_ld     = ld;
    ok        = (lat < TIMEOUT);
    wdata_exp = mdr_model[7:0];
    mdr_exp   = (is_ld && ok) ? {8'h00, rd_val} : mdr_model;
    strobe_exp = ok ? lat + 1 : TIMEOUT;
    @(negedge clk);
    ld_req = ld; st_req = st; mdr_wr = mw; mar = addr;
    c_bus = 16'($urandom); dmem_ready = 1'b0; dmem_rdata = 8'($urandom);
    for (int i = 0; i < TIMEOUT + 8; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cyc++;
      if (dmem_read) rd_cyc++;
      if (dmem_write) wr_cyc++;
      if (dmem_read && dmem_write) overlap++;
      if ((dmem_read || dmem_write) && dmem_addr !== addr) addr_bad++;
      if (dmem_write && dmem_wdata !== wdata_exp) wdata_bad++;
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        check("done_mdr", 32'(mdr_out), 32'(mdr_exp));
      end
      // garbage on every input the controller must ignore while busy
      ld_req = 1'($urandom); st_req = 1'($urandom); mdr_wr = 1'($urandom);
      mar = 16'($urandom); c_bus = 16'($urandom); dmem_rdata = 8'($urandom);
      if (i == lat) begin
        dmem_ready = 1'b1;
        dmem_rdata = rd_val;
      end else if (i > lat || i >= TIMEOUT) begin
        dmem_ready = 1'($urandom);
      end else begin
        dmem_ready = 1'b0;
      end
    end
    idle_inputs();
    check("busy_low_after", 32'(busy), 32'(0));
    check("rd_strobe_cycles", 32'(rd_cyc), 32'(is_ld ? strobe_exp : 0));
    check("wr_strobe_cycles", 32'(wr_cyc), 32'(is_ld ? 0 : strobe_exp));
    check("busy_cycles", 32'(busy_cyc), 32'(strobe_exp + 1));
    check("done_pulses", 32'(done_cnt), 32'(ok ? 1 : 0));
    check("err_pulses", 32'(err_cnt), 32'(ok ? 0 : 1));
    check("addr_stable", 32'(addr_bad), 32'(0));
    check("wdata_stable", 32'(wdata_bad), 32'(0));
    check("strobe_overlap", 32'(overlap), 32'(0));
    mdr_model = mdr_exp;
    exp_q.push_back(mdr_exp);
    check("mdr_after", 32'(mdr_out), 32'(exp_q.pop_front()));
  endtask

  initial begin
    int op;
    int lat;
    // reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mdr", 32'(mdr_out), 32'(0));
    check("rst_addr", 32'(dmem_addr), 32'(0));
    check("rst_wdata", 32'(dmem_wdata), 32'(0));
    check("rst_strobes", 32'({dmem_read, dmem_write}), 32'(0));
    check("rst_flags", 32'({busy, done, err}), 32'(0));
    rst_n = 1'b1;

    do_mdr_wr(16'hBEEF);
    do_access(1'b1, 1'b0, 1'b0, 16'h0040, 3, 8'hA5);
    do_mdr_wr(16'h12C3);
    do_access(1'b0, 1'b1, 1'b0, 16'h0010, 0, 8'h00);
    check("store_keeps_mdr", 32'(mdr_out), 32'(16'h12C3));
    do_access(1'b1, 1'b1, 1'b1, 16'h0222, 1, 8'h3C);
    do_access(1'b1, 1'b0, 1'b0, 16'h0300, TIMEOUT + 4, 8'h77);
    do_access(1'b1, 1'b0, 1'b0, 16'h0301, TIMEOUT - 1, 8'h81);
    do_access(1'b1, 1'b0, 1'b0, 16'h0302, TIMEOUT, 8'h99);
    do_access(1'b0, 1'b1, 1'b0, 16'h0303, TIMEOUT + 2, 8'h00);
    do_access(1'b0, 1'b1, 1'b1, 16'h0304, 0, 8'h00);

    // reset in the middle of a read
    do_mdr_wr(16'h5A5A);
    @(negedge clk);
    ld_req = 1'b1; mar = 16'h0123;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("mid_read_strobe", 32'(dmem_read), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_read", 32'(dmem_read), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_mdr", 32'(mdr_out), 32'(0));
    mdr_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1'b1, 1'b0, 1'b0, 16'h0124, 2, 8'h6E);

    // random traffic
    for (int t = 0; t < 40; t++) begin
      op  = $urandom_range(0, 5);
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                        : $urandom_range(0, 5);
      case (op)
        0:       do_mdr_wr(16'($urandom));
        1, 2:    do_access(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), lat, 8'($urandom));
        3, 4:    do_access(1'b0, 1'b1, 1'($urandom), 16'($urandom), lat, 8'($urandom));
        default: do_access(1'b1, 1'b1, 1'b1, 16'($urandom), lat, 8'($urandom));
      endcase
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdr_mem_ctrl.md
Name: mdr_mem_ctrl

Overview:
Sequencer for the memory data register (MDR) path between the 16-bit C bus datapath and the 8-bit data memory. It owns the MDR and accepts load, store and direct-write commands from the control unit. It drives the data-memory read/write strobes with a ready handshake and a timeout, and reports busy/done/err back to the control unit. It replaces edge-triggered strobe capture with a single-clock FSM.

Parameters:
TIMEOUT, 16, max cycles to wait for dmem_ready before aborting (>=1)
CNT_W, 5, width of timeout counter (2^CNT_W > TIMEOUT)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
ld_req  input  1  load command: read dmem[mar] into MDR (sampled in IDLE only)
st_req  input  1  store command: write MDR[7:0] to dmem[mar] (sampled in IDLE only)
mdr_wr  input  1  load MDR from c_bus (sampled in IDLE only)
c_bus  input  16  datapath C bus
mar  input  16  memory address register value
dmem_rdata  input  8  data memory read data, valid when dmem_ready=1 during read
dmem_ready  input  1  memory handshake: read data valid / write accepted
dmem_addr  output  16  address to data memory
dmem_wdata  output  8  write data to data memory
dmem_read  output  1  read strobe, held until ready or timeout
dmem_write  output  1  write strobe, held until ready or timeout
mdr_out  output  16  current MDR contents
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on successful completion of ld/st
err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst_n=0, async): state=IDLE, mdr_out=0, dmem_addr=0, dmem_wdata=0, dmem_read=0, dmem_write=0, done=0, err=0, counter=0.
- States: IDLE, RD_WAIT, WR_WAIT, DONE, ERR. All outputs registered.
- IDLE priority: ld_req > st_req > mdr_wr; lower-priority commands in the same cycle are dropped (no queueing).
- IDLE, mdr_wr only: mdr_out <= c_bus at that edge; stay IDLE; no done pulse.
- IDLE, ld_req: latch dmem_addr<=mar, dmem_read<=1, counter<=0, go RD_WAIT.
- IDLE, st_req: latch dmem_addr<=mar, dmem_wdata<=mdr_out[7:0], dmem_write<=1, counter<=0, go WR_WAIT.
- RD_WAIT, dmem_ready=1: mdr_out <= {8'h00, dmem_rdata} (zero-extend), dmem_read<=0, go DONE.
- WR_WAIT, dmem_ready=1: dmem_write<=0, go DONE; MDR unchanged.
- WAIT states, dmem_ready=0: counter+1; when counter reaches TIMEOUT-1 with no ready, drop strobe, go ERR; MDR unchanged.
- DONE: done=1 for exactly one cycle, then IDLE. ERR: err=1 for exactly one cycle, then IDLE.
- Min load latency: ld_req at edge 0 -> dmem_read high from edge 0; ready seen at edge 1 -> mdr_out valid and done high after edge 1; busy low after edge 2.
- ld_req/st_req/mdr_wr while busy: ignored; control unit must hold or reissue after busy falls.
- dmem_addr/dmem_wdata stable for the whole strobe; mar/c_bus changes mid-access have no effect.
- dmem_ready in IDLE/DONE/ERR: ignored.
- dmem_read and dmem_write never high together.
- Reset mid-access: strobes drop immediately (async), MDR cleared to 0.

Test Plan:
- Reset, then mdr_wr=1 c_bus=16'hBEEF -> mdr_out=16'hBEEF next cycle, busy stays 0, no done.
- ld_req mar=16'h0040, ready after 3 wait cycles with dmem_rdata=8'hA5 -> dmem_read high 4 cycles, mdr_out=16'h00A5, single done pulse, addr 16'h0040 throughout.
- After mdr=16'h12C3, st_req mar=16'h0010, ready immediately -> dmem_write one cycle, dmem_wdata=8'hC3, done pulse, mdr_out unchanged.
- ld_req+st_req+mdr_wr same cycle -> only read performed; MDR not loaded from c_bus; no write strobe.
- ld_req with dmem_ready held 0 (TIMEOUT=16) -> dmem_read drops after 16 cycles, err pulse, no done, mdr_out unchanged.
- rst_n asserted during RD_WAIT -> dmem_read, busy, mdr_out go 0 without a clock edge; next ld_req completes normally.
